// File: rtl/rtc_time_setter.sv
// rtl/rtc_time_setter.sv - push-button time-set front end for the RTC
// Debounces mode/up/down buttons and drives the RTC load strobe with new hour/minute values.

module rtc_btn_debounce #(
  parameter int CYC = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Level flips once the synced input has differed for CYC consecutive samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= 2'b00;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], btn};
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_q;
endmodule

module rtc_time_setter #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int TIMEOUT_S   = 10
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [7:0] i_cur_min,
  input  logic [7:0] i_cur_hour,
  output logic       o_modify,
  output logic [7:0] o_im_min,
  output logic [7:0] o_im_hour,
  output logic [1:0] o_set_mode
);
  localparam int DEBOUNCE_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int TIMEOUT_CYC  = CLK_HZ * TIMEOUT_S;
  localparam int TW           = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          mode_p;
  logic          up_p;
  logic          down_p;
  logic          any_p;
  logic          inc;
  logic          dec;

  rtc_btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(i_clk), .reset_n(i_reset_n), .btn(i_btn_mode), .press(mode_p)
  );
  rtc_btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db_up (
    .clk(i_clk), .reset_n(i_reset_n), .btn(i_btn_up), .press(up_p)
  );
  rtc_btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db_down (
    .clk(i_clk), .reset_n(i_reset_n), .btn(i_btn_down), .press(down_p)
  );

  // Mode wins over up/down; up and down together cancel out.
  assign any_p = mode_p | up_p | down_p;
  assign inc   = up_p & ~down_p & ~mode_p;
  assign dec   = down_p & ~up_p & ~mode_p;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= RUN;
      tcnt      <= '0;
      o_modify  <= 1'b0;
      o_im_min  <= 8'd0;
      o_im_hour <= 8'd0;
    end else begin
      o_modify <= 1'b0;
      case (state)
        RUN: begin
          tcnt <= '0;
          if (mode_p) begin
            o_im_hour <= (i_cur_hour > 8'd23) ? 8'd0 : i_cur_hour;
            o_im_min  <= (i_cur_min > 8'd59) ? 8'd0 : i_cur_min;
            state     <= SET_HOUR;
          end
        end
        SET_HOUR: begin
          if (mode_p) begin
            state <= SET_MIN;
            tcnt  <= '0;
          end else if (any_p) begin
            tcnt <= '0;
            if (inc) begin
              o_im_hour <= (o_im_hour == 8'd23) ? 8'd0 : o_im_hour + 8'd1;
            end else if (dec) begin
              o_im_hour <= (o_im_hour == 8'd0) ? 8'd23 : o_im_hour - 8'd1;
            end
          end else if (tcnt == TIMEOUT_LAST) begin
            state <= RUN;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        SET_MIN: begin
          if (mode_p) begin
            state    <= COMMIT;
            o_modify <= 1'b1;
            tcnt     <= '0;
          end else if (any_p) begin
            tcnt <= '0;
            if (inc) begin
              o_im_min <= (o_im_min == 8'd59) ? 8'd0 : o_im_min + 8'd1;
            end else if (dec) begin
              o_im_min <= (o_im_min == 8'd0) ? 8'd59 : o_im_min - 8'd1;
            end
          end else if (tcnt == TIMEOUT_LAST) begin
            state <= RUN;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        COMMIT: begin
          state <= RUN;
          tcnt  <= '0;
        end
      endcase
    end
  end

  assign o_set_mode = state;
endmodule

// File: tb/tb_rtc_time_setter.sv
// tb/tb_rtc_time_setter.sv - directed bench for rtc_time_setter
// Debounce of 4 cycles and timeout of 2000 cycles via parameter overrides.

module tb_rtc_time_setter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic [7:0] cur_min = 8'd0;
  logic [7:0] cur_hour = 8'd0;
  logic       modify;
  logic [7:0] im_min;
  logic [7:0] im_hour;
  logic [1:0] set_mode;

  int         checks = 0;
  int         errors = 0;
  int         mod_count = 0;
  logic       mod_prev = 1'b0;
  logic [7:0] mod_hour = 8'd0;
  logic [7:0] mod_min = 8'd0;

  rtc_time_setter #(
    .CLK_HZ(1000),
    .DEBOUNCE_MS(4),
    .TIMEOUT_S(2)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_btn_mode(mode),
    .i_btn_up(up),
    .i_btn_down(down),
    .i_cur_min(cur_min),
    .i_cur_hour(cur_hour),
    .o_modify(modify),
    .o_im_min(im_min),
    .o_im_hour(im_hour),
    .o_set_mode(set_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    @(negedge clk);
    mode = m;
    up   = u;
    down = d;
    repeat (10) @(negedge clk);
    mode = 1'b0;
    up   = 1'b0;
    down = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic glitch_up();
    @(negedge clk);
    up = 1'b1;
    repeat (3) @(negedge clk);
    up = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Commit-strobe monitor: pulse width, return to RUN, and values held during the pulse.
  always @(negedge clk) begin
    if (mod_prev) begin
      check("modify_one_cycle", {31'd0, modify}, 32'd0);
      check("run_after_commit", {30'd0, set_mode}, 32'd0);
    end
    if (modify) begin
      mod_count++;
      mod_hour = im_hour;
      mod_min  = im_min;
    end
    mod_prev = modify;
  end

  initial begin
    cur_hour = 8'd13;
    cur_min  = 8'd45;
    repeat (3) @(negedge clk);
    check("reset_modify", {31'd0, modify}, 32'd0);
    check("reset_min", {24'd0, im_min}, 32'd0);
    check("reset_hour", {24'd0, im_hour}, 32'd0);
    check("reset_mode", {30'd0, set_mode}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Capture and entry into SET_HOUR within 7 cycles
    mode = 1'b1;
    repeat (7) @(negedge clk);
    check("enter_set_hour", {30'd0, set_mode}, 32'd1);
    check("cap_hour", {24'd0, im_hour}, 32'd13);
    check("cap_min", {24'd0, im_min}, 32'd45);
    check("cap_no_modify", {31'd0, modify}, 32'd0);
    repeat (3) @(negedge clk);
    mode = 1'b0;
    repeat (10) @(negedge clk);

    // Full flow ending in a single commit
    press(1'b0, 1'b1, 1'b0);
    check("flow_hour_inc", {24'd0, im_hour}, 32'd14);
    press(1'b1, 1'b0, 1'b0);
    check("flow_set_min", {30'd0, set_mode}, 32'd2);
    press(1'b0, 1'b1, 1'b0);
    check("flow_min_inc", {24'd0, im_min}, 32'd46);
    press(1'b1, 1'b0, 1'b0);
    check("flow_mod_count", mod_count, 32'd1);
    check("flow_mod_hour", {24'd0, mod_hour}, 32'd14);
    check("flow_mod_min", {24'd0, mod_min}, 32'd46);
    check("flow_back_run", {30'd0, set_mode}, 32'd0);
    check("flow_hold_hour", {24'd0, im_hour}, 32'd14);
    check("flow_hold_min", {24'd0, im_min}, 32'd46);

    // Up ignored in RUN; out-of-range minute captured as 0
    press(1'b0, 1'b1, 1'b0);
    check("run_ignores_up", {30'd0, set_mode}, 32'd0);
    check("run_up_no_change", {24'd0, im_hour}, 32'd14);
    cur_hour = 8'd23;
    cur_min  = 8'd70;
    press(1'b1, 1'b0, 1'b0);
    check("cap23_hour", {24'd0, im_hour}, 32'd23);
    check("cap70_min", {24'd0, im_min}, 32'd0);
    press(1'b0, 1'b1, 1'b0);
    check("hour_wrap_up", {24'd0, im_hour}, 32'd0);
    press(1'b0, 1'b0, 1'b1);
    check("hour_wrap_down", {24'd0, im_hour}, 32'd23);
    press(1'b0, 1'b0, 1'b1);
    check("hour_dec", {24'd0, im_hour}, 32'd22);

    // Bounce rejection and simultaneous presses
    glitch_up();
    glitch_up();
    glitch_up();
    check("glitch_hour", {24'd0, im_hour}, 32'd22);
    check("glitch_mode", {30'd0, set_mode}, 32'd1);
    press(1'b0, 1'b1, 1'b1);
    check("updown_hour", {24'd0, im_hour}, 32'd22);
    check("updown_mode", {30'd0, set_mode}, 32'd1);
    press(1'b1, 1'b1, 1'b0);
    check("modeup_state", {30'd0, set_mode}, 32'd2);
    check("modeup_hour", {24'd0, im_hour}, 32'd22);
    check("modeup_min", {24'd0, im_min}, 32'd0);
    press(1'b0, 1'b0, 1'b1);
    check("min_wrap_down", {24'd0, im_min}, 32'd59);

    // Timeout: last press pulse was about 13 cycles ago
    repeat (1900) @(negedge clk);
    check("pre_timeout_mode", {30'd0, set_mode}, 32'd2);
    repeat (150) @(negedge clk);
    check("timeout_mode", {30'd0, set_mode}, 32'd0);
    check("timeout_hour", {24'd0, im_hour}, 32'd22);
    check("timeout_min", {24'd0, im_min}, 32'd59);
    check("timeout_no_mod", mod_count, 32'd1);

    // Asynchronous reset in the middle of an edit
    cur_hour = 8'd5;
    cur_min  = 8'd10;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("pre_reset_mode", {30'd0, set_mode}, 32'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mode", {30'd0, set_mode}, 32'd0);
    check("async_hour", {24'd0, im_hour}, 32'd0);
    check("async_min", {24'd0, im_min}, 32'd0);
    check("async_modify", {31'd0, modify}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_mode", {30'd0, set_mode}, 32'd0);
    check("post_reset_modify", {31'd0, modify}, 32'd0);
    check("post_reset_mod_count", mod_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
